// File: rtl/rf_port_arbiter.sv
// Two-client register-file port arbiter.
// Clients A and B share one register-file port. One command is in flight at a
// time, and the IDLE -> ISSUE (-> RESP) -> IDLE sequence carries it.
// Handshake: while the FSM is in IDLE, a client's gnt is a combinational
// single-cycle pulse. In that cycle the command (wr/addr/wdata) is latched.
// After gnt the client may drop req or change its command inputs without
// affecting the accepted command. For a read, the owner's rvalid pulses for
// exactly one cycle, and its rdata then holds until that client's next read.
module rf_port_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic              a_wr,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_wr,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] rf_writenum,
  output logic [ADDR_W-1:0] rf_readnum,
  output logic              rf_write,
  output logic [DATA_W-1:0] rf_data_in,
  input  logic [DATA_W-1:0] rf_data_out,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                w_gnt_a;
  logic                w_gnt_b;
  logic                r_prio_b;   // 1: B wins the next tie, 0: A wins
  logic                r_cmd_wr;
  logic                r_owner_b;
  logic [ADDR_W-1:0]   r_writenum;
  logic [ADDR_W-1:0]   r_readnum;
  logic [DATA_W-1:0]   r_data_in;
  logic [DATA_W-1:0]   r_a_rdata;
  logic [DATA_W-1:0]   r_b_rdata;

  // Next-state and grant decode; grants only exist in IDLE.
  always_comb begin
    w_next_state = r_state;
    w_gnt_a      = 1'b0;
    w_gnt_b      = 1'b0;
    case (r_state)
      IDLE: begin
        if (a_req || b_req) begin
          w_gnt_a      = a_req && (!b_req || !r_prio_b);
          w_gnt_b      = b_req && !w_gnt_a;
          w_next_state = ISSUE;
        end
      end
      ISSUE:   w_next_state = r_cmd_wr ? IDLE : RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // State register; reset aborts any in-flight command.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // Latch the winner's command and flip round-robin priority on each grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prio_b   <= 1'b0;
      r_cmd_wr   <= 1'b0;
      r_owner_b  <= 1'b0;
      r_writenum <= '0;
      r_readnum  <= '0;
      r_data_in  <= '0;
    end else if (w_gnt_a) begin
      r_prio_b   <= 1'b1;
      r_cmd_wr   <= a_wr;
      r_owner_b  <= 1'b0;
      r_writenum <= a_addr;
      r_readnum  <= a_addr;
      r_data_in  <= a_wdata;
    end else if (w_gnt_b) begin
      r_prio_b   <= 1'b0;
      r_cmd_wr   <= b_wr;
      r_owner_b  <= 1'b1;
      r_writenum <= b_addr;
      r_readnum  <= b_addr;
      r_data_in  <= b_wdata;
    end
  end

  // Capture read data into the owner's holding register at the end of ISSUE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else if (r_state == ISSUE && !r_cmd_wr) begin
      if (r_owner_b) r_b_rdata <= rf_data_out;
      else           r_a_rdata <= rf_data_out;
    end
  end

  assign a_gnt       = w_gnt_a;
  assign b_gnt       = w_gnt_b;
  assign rf_write    = (r_state == ISSUE) && r_cmd_wr;
  assign a_rvalid    = (r_state == RESP) && !r_cmd_wr && !r_owner_b;
  assign b_rvalid    = (r_state == RESP) && !r_cmd_wr && r_owner_b;
  assign a_rdata     = r_a_rdata;
  assign b_rdata     = r_b_rdata;
  assign rf_writenum = r_writenum;
  assign rf_readnum  = r_readnum;
  assign rf_data_in  = r_data_in;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Bench for rf_port_arbiter: directed scenarios plus random two-client traffic,
// checked against a transaction-level model (register array, round-robin bit).
module tb_rf_port_arbiter;
  localparam int DW = 16;
  localparam int AW = 3;

  // Clock and reset.
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic          a_req, a_wr, a_gnt, a_rvalid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rdata;
  logic          b_req, b_wr, b_gnt, b_rvalid;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rdata;
  logic [AW-1:0] rf_writenum, rf_readnum;
  logic          rf_write;
  logic [DW-1:0] rf_data_in, rf_data_out;
  logic [1:0]    dbg_state;

  rf_port_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .rf_writenum(rf_writenum), .rf_readnum(rf_readnum), .rf_write(rf_write),
    .rf_data_in(rf_data_in), .rf_data_out(rf_data_out),
    .o_dbg_state(dbg_state)
  );

  // External register file attached to the port (not reset).
  logic [DW-1:0] hw_rf [8] = '{default: 16'h0000};
  always @(posedge clk) if (rf_write) hw_rf[rf_writenum] <= rf_data_in;
  assign rf_data_out = hw_rf[rf_readnum];

  // Reference model state.
  logic [DW-1:0] model_rf [8] = '{default: 16'h0000};
  bit            model_prio_b;
  logic [DW-1:0] model_a_rdata, model_b_rdata;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command from one or both clients and follow the winner to completion.
  task automatic run_cmd(input bit ra, input bit rb,
                         input bit awr, input logic [AW-1:0] aad, input logic [DW-1:0] awd,
                         input bit bwr, input logic [AW-1:0] bad, input logic [DW-1:0] bwd);
    bit            win_b;
    bit            wr;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd;
    @(negedge clk);
    a_req = ra; a_wr = awr; a_addr = aad; a_wdata = awd;
    b_req = rb; b_wr = bwr; b_addr = bad; b_wdata = bwd;
    #1;
    win_b = (ra && rb) ? model_prio_b : rb;
    chk("gnt_a", 32'(a_gnt), 32'(!win_b));
    chk("gnt_b", 32'(b_gnt), 32'(win_b));
    model_prio_b = !win_b;
    wr = win_b ? bwr : awr;
    ad = win_b ? bad : aad;
    wd = win_b ? bwd : awd;
    // Withdraw and scramble the request right after the grant.
    @(negedge clk);
    a_req = 1'b0; b_req = 1'b0;
    a_wdata = 16'hFFFF; b_wdata = 16'hFFFF;
    a_addr = ~aad; b_addr = ~bad; a_wr = ~awr; b_wr = ~bwr;
    #1;
    chk("issue_gnt", 32'({a_gnt, b_gnt}), 32'd0);
    chk("issue_rf_write", 32'(rf_write), 32'(wr));
    chk("issue_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
    if (wr) begin
      chk("issue_writenum", 32'(rf_writenum), 32'(ad));
      chk("issue_data_in", 32'(rf_data_in), 32'(wd));
      model_rf[ad] = wd;
    end else begin
      chk("issue_readnum", 32'(rf_readnum), 32'(ad));
    end
    @(negedge clk); #1;
    if (wr) begin
      chk("post_wr_rf_write", 32'(rf_write), 32'd0);
      chk("post_wr_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
    end else begin
      if (win_b) model_b_rdata = model_rf[ad];
      else       model_a_rdata = model_rf[ad];
      chk("resp_rvalid", 32'({a_rvalid, b_rvalid}), win_b ? 32'd1 : 32'd2);
      chk("resp_a_rdata", 32'(a_rdata), 32'(model_a_rdata));
      chk("resp_b_rdata", 32'(b_rdata), 32'(model_b_rdata));
      chk("resp_rf_write", 32'(rf_write), 32'd0);
      @(negedge clk); #1;
      chk("post_resp_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    a_req = 0; a_wr = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_wr = 0; b_addr = '0; b_wdata = '0;
    model_prio_b = 1'b0; model_a_rdata = '0; model_b_rdata = '0;

    // Reset values.
    @(negedge clk); #1;
    chk("rst_gnt", 32'({a_gnt, b_gnt}), 32'd0);
    chk("rst_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
    chk("rst_rf_write", 32'(rf_write), 32'd0);
    chk("rst_nums", 32'({rf_writenum, rf_readnum}), 32'd0);
    chk("rst_data_in", 32'(rf_data_in), 32'd0);
    chk("rst_rdata", 32'({a_rdata, b_rdata}), 32'd0);
    @(negedge clk); reset_n = 1'b1;

    // Simultaneous requests from reset alternate A, B, A, B.
    run_cmd(1, 1, 1, 3'd0, 16'h0A00, 1, 3'd7, 16'h0B07);
    run_cmd(1, 1, 1, 3'd0, 16'h0A01, 1, 3'd7, 16'h0B08);
    run_cmd(1, 1, 1, 3'd0, 16'h0A02, 1, 3'd7, 16'h0B09);
    run_cmd(1, 1, 1, 3'd0, 16'h0A03, 1, 3'd7, 16'h0B0A);

    // A writes R3 then reads it back.
    run_cmd(1, 0, 1, 3'd3, 16'h1234, 0, 3'd0, 16'h0000);
    run_cmd(1, 0, 0, 3'd3, 16'h0000, 0, 3'd0, 16'h0000);

    // B reads R5 while A reads R6.
    run_cmd(0, 1, 0, 3'd0, 16'h0000, 1, 3'd5, 16'h5A5A);
    run_cmd(1, 0, 1, 3'd6, 16'h6B6B, 0, 3'd0, 16'h0000);
    run_cmd(1, 1, 0, 3'd6, 16'h0000, 0, 3'd5, 16'h0000);
    run_cmd(1, 1, 0, 3'd6, 16'h0000, 0, 3'd5, 16'h0000);

    // Write R1 with post-grant scrambling, then read it back.
    run_cmd(1, 0, 1, 3'd1, 16'h00AA, 0, 3'd0, 16'h0000);
    run_cmd(1, 0, 0, 3'd1, 16'h0000, 0, 3'd0, 16'h0000);

    // Held request with no competitor is re-granted every two cycles.
    @(negedge clk);
    a_req = 1; a_wr = 1; a_addr = 3'd4; a_wdata = 16'hBEEF; b_req = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold_gnt", 32'(a_gnt), 32'd1);
      @(negedge clk);
      if (k == 2) a_req = 1'b0;
      #1;
      chk("hold_rf_write", 32'(rf_write), 32'd1);
      chk("hold_writenum", 32'(rf_writenum), 32'd4);
      @(negedge clk);
    end
    #1;
    chk("hold_end_gnt", 32'(a_gnt), 32'd0);
    model_prio_b = 1'b1;
    model_rf[4]  = 16'hBEEF;
    run_cmd(0, 1, 0, 3'd0, 16'h0000, 0, 3'd4, 16'h0000);

    // Reset pulse during ISSUE of a write aborts it.
    run_cmd(1, 0, 1, 3'd2, 16'h1111, 0, 3'd0, 16'h0000);
    @(negedge clk);
    a_req = 1; a_wr = 1; a_addr = 3'd2; a_wdata = 16'h5555;
    #1;
    chk("abort_gnt", 32'(a_gnt), 32'd1);
    @(negedge clk);
    a_req = 0;
    #1;
    chk("abort_issue_write", 32'(rf_write), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_rf_write", 32'(rf_write), 32'd0);
    chk("abort_nums", 32'({rf_writenum, rf_readnum}), 32'd0);
    chk("abort_data_in", 32'(rf_data_in), 32'd0);
    chk("abort_rdata", 32'({a_rdata, b_rdata}), 32'd0);
    model_prio_b = 1'b0; model_a_rdata = '0; model_b_rdata = '0;
    @(negedge clk); reset_n = 1'b1;

    // Quiet period: nothing may assert.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      chk("idle_gnt", 32'({a_gnt, b_gnt}), 32'd0);
      chk("idle_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
      chk("idle_rf_write", 32'(rf_write), 32'd0);
    end
    run_cmd(1, 0, 0, 3'd2, 16'h0000, 0, 3'd0, 16'h0000);
    run_cmd(1, 1, 0, 3'd7, 16'h0000, 0, 3'd0, 16'h0000);

    // Random mixed traffic.
    for (int n = 0; n < 60; n++) begin
      bit ra, rb;
      ra = 1'($urandom_range(0, 1));
      rb = ra ? 1'($urandom_range(0, 1)) : 1'b1;
      run_cmd(ra, rb,
              1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
              1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
